uart_prog_loader: RTL and testbench
===================================

// Module: uart_prog_loader
// PURPOSE
//  UART boot loader feeding the program ROM write port (upg_* bus) of the instruction-fetch stage.
//  - Receives 8N1 serial bytes and assembles them little-endian into 32-bit words.
//  - Issues one write pulse per word with a 15-bit word address, then raises done.
//  - Done hands the ROM port back to the CPU clock.
//  - Address bit 14 = 0 targets instruction memory; bit 14 = 1 targets data memory.
// PARAMETERS
//  CLKS_PER_BIT  434  upg_clk_i cycles per UART bit (50 MHz / 115200); legal range is >= 4.
//  BASE_ADR      0    15-bit word address of the first written word.
// PORTS
//  upg_clk_i    in   1   single clock, rising edge
//  upg_rst_i    in   1   reset, synchronous, active-high
//  rx_i         in   1   UART RX line, asynchronous, idle high
//  upg_wen_o    out  1   word write strobe, exactly 1 cycle wide
//  upg_adr_o    out  15  word address, valid while upg_wen_o is high
//  upg_dat_o    out  32  word data, valid while upg_wen_o is high
//  upg_done_o   out  1   load complete; sticky until reset
//  busy_o       out  1   load in progress (from the first header byte until done)
//  frame_err_o  out  1   sticky: a stop bit was sampled as 0
//  chk_err_o    out  1   sticky: checksum mismatch (constant 0 when the macro is absent)
// BEHAVIOUR
//  Reset: all outputs are 0; FSM enters IDLE; word index = BASE_ADR; byte lane = 0.
//    Reset in any state aborts the load, and a partially assembled word is discarded.
//  RX path: rx_i passes through a 2-FF synchroniser (2 cycles latency).
//    - A falling edge in RX_IDLE starts a byte.
//    - The start bit is re-checked at CLKS_PER_BIT/2; if it is high, the event is a glitch and the receiver returns to RX_IDLE.
//    - 8 data bits are then sampled LSB first, every CLKS_PER_BIT cycles, followed by the stop bit.
//    - byte_vld pulses 1 cycle at the stop sample.
//    - Stop bit = 0: the byte is dropped, frame_err_o is set, and the load FSM is unaffected.
//  Protocol: HDR0, HDR1 = word count N (little-endian, 15 bits used; bit 15 ignored), then N*4 data bytes, LSB first.
//  Load FSM states: IDLE -> HDR1 -> DATA -> (CHK) -> DONE.
//    - IDLE: the first valid byte becomes N[7:0] and busy_o is set; go to HDR1.
//    - HDR1: the next byte becomes N[14:8]. If N == 0, go straight to DONE; otherwise go to DATA.
//    - DATA: the byte is written into lane [8*lane +: 8].
//      - On lane 3, upg_wen_o is asserted the next cycle with the assembled word and the current index.
//      - The index then increments, wrapping modulo 2^15. The remaining count decrements.
//      - When count reaches 0 after that write, go to DONE, or to CHK when the macro is present.
//    - DONE: upg_done_o = 1 and busy_o = 0. Further bytes are ignored until reset.
//  Simultaneous events: upg_wen_o and the DONE transition may share a cycle.
//    upg_done_o rises in the cycle after the final upg_wen_o pulse.
//  Latency: the final stop-bit sample reaches upg_wen_o in 1 cycle; upg_wen_o reaches upg_done_o in 1 cycle.
//  upg_adr_o and upg_dat_o hold their last values between strobes.
// CONFIGURATION
//  Macro UART_PROG_LOADER_CHKSUM_EN.
//  - Defined:
//    - After the last data byte, one extra byte is expected.
//    - It must equal the 8-bit two's-complement of the sum of all data bytes (header excluded).
//    - A mismatch sets chk_err_o; the FSM still enters DONE, and the written words are not rolled back.
//  - Undefined:
//    - There is no CHK state; the FSM enters DONE right after the last word.
//    - chk_err_o is tied to 0.
// STRUCTURE
//  Shared header uart_loader_defs.vh holds:
//  - FSM state localparams (ST_IDLE, ST_HDR1, ST_DATA, ST_CHK, ST_DONE), 3-bit.
//  - RX state localparams (RX_IDLE, RX_START, RX_DATA, RX_STOP).
//  - ADR_W = 15 and DAT_W = 32.
//  Sub-module uart_rx_byte (params: CLKS_PER_BIT) contains the synchroniser, bit-timing counter and shift register.
//    Its outputs are byte_o[7:0], byte_vld_o and frame_err_o (1-cycle pulse).
//  The top level contains the header/lane/count FSM and the optional checksum accumulator.
// TESTING  (bench drives rx_i with CLKS_PER_BIT=8, BASE_ADR=0)
//  1. Bytes 02 00 13 05 10 00 93 05 20 00 ->
//     - two upg_wen_o pulses: adr 0 / dat 0x00100513, then adr 1 / dat 0x00200593;
//     - then upg_done_o = 1.
//  2. Bytes 00 00 -> no upg_wen_o pulse; upg_done_o = 1 one cycle after the second stop bit.
//  3. Start-bit glitch of 3 cycles low on an idle line -> no byte_vld, no outputs change.
//     Then send 01 00 EF BE AD DE -> adr 0 / dat 0xDEADBEEF.
//  4. Header 01 00, then a byte with stop bit forced to 0, then AA BB CC DD ->
//     - frame_err_o = 1;
//     - dat 0xDDCCBBAA at adr 0 (the bad byte is dropped);
//     - upg_done_o = 1.
//  5. upg_rst_i pulsed for 1 cycle after 2 data bytes of a 1-word load ->
//     - all outputs return to 0;
//     - a fresh 01 00 11 22 33 44 load writes adr 0 / dat 0x44332211.
//  6. With CHKSUM_EN, bytes 01 00 01 02 03 04 F6 -> chk_err_o = 0.
//     The same stream ending in 00 instead of F6 -> chk_err_o = 1 and upg_done_o = 1.

Source files
------------

// File: rtl/uart_prog_loader_pkg.sv
// rtl/uart_prog_loader_pkg.sv - shared widths and state encodings for the UART program loader
package uart_prog_loader_pkg;

  localparam int ADR_W = 15;
  localparam int DAT_W = 32;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HDR1 = 3'd1,
    ST_DATA = 3'd2,
    ST_CHK  = 3'd3,
    ST_DONE = 3'd4
  } ld_state_t;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

endpackage

// File: rtl/uart_prog_loader_rx.sv
// rtl/uart_prog_loader_rx.sv - 8N1 byte receiver: synchroniser, bit timing and shift register
module uart_rx_byte
  import uart_prog_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] byte_o,
  output logic       byte_vld_o,
  output logic       frame_err_o
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST      = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

  logic            sync1, sync2, prev;
  rx_state_t       state, state_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic [2:0]      bit_idx, bit_idx_n;
  logic [7:0]      shreg, shreg_n;
  logic            vld_n, ferr_n;

  // prev is the synchronised line one cycle earlier, used for falling-edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1       <= 1'b1;
      sync2       <= 1'b1;
      prev        <= 1'b1;
      state       <= RX_IDLE;
      cnt         <= '0;
      bit_idx     <= '0;
      shreg       <= '0;
      byte_vld_o  <= 1'b0;
      frame_err_o <= 1'b0;
    end else begin
      sync1       <= rx;
      sync2       <= sync1;
      prev        <= sync2;
      state       <= state_n;
      cnt         <= cnt_n;
      bit_idx     <= bit_idx_n;
      shreg       <= shreg_n;
      byte_vld_o  <= vld_n;
      frame_err_o <= ferr_n;
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt + 1'b1;
    bit_idx_n = bit_idx;
    shreg_n   = shreg;
    vld_n     = 1'b0;
    ferr_n    = 1'b0;
    case (state)
      RX_IDLE: begin
        cnt_n = '0;
        if (prev && !sync2) state_n = RX_START;
      end
      RX_START: begin
        if (cnt == HALF_LAST) begin
          cnt_n     = '0;
          bit_idx_n = '0;
          state_n   = sync2 ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (cnt == LAST) begin
          cnt_n     = '0;
          shreg_n   = {sync2, shreg[7:1]};
          bit_idx_n = bit_idx + 3'd1;
          if (bit_idx == 3'd7) state_n = RX_STOP;
        end
      end
      RX_STOP: begin
        if (cnt == LAST) begin
          cnt_n   = '0;
          state_n = RX_IDLE;
          vld_n   = sync2;
          ferr_n  = !sync2;
        end
      end
      default: state_n = RX_IDLE;
    endcase
  end

  assign byte_o = shreg;

endmodule

// File: rtl/uart_prog_loader.sv
// rtl/uart_prog_loader.sv - UART boot loader writing words to the program ROM port; checksum via UART_PROG_LOADER_CHKSUM_EN
module uart_prog_loader
  import uart_prog_loader_pkg::*;
#(
  parameter int                CLKS_PER_BIT = 434,
  parameter logic [ADR_W-1:0]  BASE_ADR     = '0
) (
  input  logic              upg_clk_i,
  input  logic              upg_rst_i,
  input  logic              rx_i,
  output logic              upg_wen_o,
  output logic [ADR_W-1:0]  upg_adr_o,
  output logic [DAT_W-1:0]  upg_dat_o,
  output logic              upg_done_o,
  output logic              busy_o,
  output logic              frame_err_o,
  output logic              chk_err_o
);

  logic [7:0]       rx_byte;
  logic             rx_vld, rx_ferr;
  ld_state_t        state, state_n;
  logic [7:0]       n_lo;
  logic [ADR_W-1:0] count, idx;
  logic [1:0]       lane;
  logic [23:0]      word_buf;

  uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk        (upg_clk_i),
    .rst        (upg_rst_i),
    .rx         (rx_i),
    .byte_o     (rx_byte),
    .byte_vld_o (rx_vld),
    .frame_err_o(rx_ferr)
  );

  always_ff @(posedge upg_clk_i) begin
    if (upg_rst_i) state <= ST_IDLE;
    else           state <= state_n;
  end

  // Leaving DATA waits for the final strobe so done rises the cycle after it
  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE: if (rx_vld) state_n = ST_HDR1;
      ST_HDR1: if (rx_vld) state_n = ({rx_byte[6:0], n_lo} == '0) ? ST_DONE : ST_DATA;
      ST_DATA: begin
        if (upg_wen_o && count == '0) begin
`ifdef UART_PROG_LOADER_CHKSUM_EN
          state_n = ST_CHK;
`else
          state_n = ST_DONE;
`endif
        end
      end
      ST_CHK:  if (rx_vld) state_n = ST_DONE;
      ST_DONE: state_n = ST_DONE;
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge upg_clk_i) begin
    if (upg_rst_i) begin
      n_lo        <= '0;
      count       <= '0;
      idx         <= BASE_ADR;
      lane        <= '0;
      word_buf    <= '0;
      upg_wen_o   <= 1'b0;
      upg_adr_o   <= '0;
      upg_dat_o   <= '0;
      frame_err_o <= 1'b0;
    end else begin
      upg_wen_o <= 1'b0;
      if (rx_ferr) frame_err_o <= 1'b1;
      if (rx_vld) begin
        case (state)
          ST_IDLE: n_lo  <= rx_byte;
          ST_HDR1: count <= {rx_byte[6:0], n_lo};
          ST_DATA: begin
            lane <= lane + 2'd1;
            case (lane)
              2'd0: word_buf[7:0]   <= rx_byte;
              2'd1: word_buf[15:8]  <= rx_byte;
              2'd2: word_buf[23:16] <= rx_byte;
              default: begin
                upg_wen_o <= 1'b1;
                upg_adr_o <= idx;
                upg_dat_o <= {rx_byte, word_buf};
                idx       <= idx + 1'b1;
                count     <= count - 1'b1;
              end
            endcase
          end
          default: ;
        endcase
      end
    end
  end

`ifdef UART_PROG_LOADER_CHKSUM_EN
  logic [7:0] sum;
  // Data bytes plus a correct checksum byte add up to zero modulo 256
  always_ff @(posedge upg_clk_i) begin
    if (upg_rst_i) begin
      sum       <= '0;
      chk_err_o <= 1'b0;
    end else if (rx_vld) begin
      if (state == ST_DATA) sum <= sum + rx_byte;
      if (state == ST_CHK && (sum + rx_byte) != 8'd0) chk_err_o <= 1'b1;
    end
  end
`else
  assign chk_err_o = 1'b0;
`endif

  assign upg_done_o = (state == ST_DONE);
  assign busy_o     = (state != ST_IDLE) && (state != ST_DONE);

endmodule

// File: tb/tb_uart_prog_loader.sv
// tb/tb_uart_prog_loader.sv - scoreboard bench for uart_prog_loader driving 8N1 serial streams
module tb_uart_prog_loader;

  localparam int CPB = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx;
  logic        upg_wen_o;
  logic [14:0] upg_adr_o;
  logic [31:0] upg_dat_o;
  logic        upg_done_o, busy_o, frame_err_o, chk_err_o;

  always #5 clk = ~clk;

  uart_prog_loader #(.CLKS_PER_BIT(CPB), .BASE_ADR(15'd0)) dut (
    .upg_clk_i  (clk),
    .upg_rst_i  (rst),
    .rx_i       (rx),
    .upg_wen_o  (upg_wen_o),
    .upg_adr_o  (upg_adr_o),
    .upg_dat_o  (upg_dat_o),
    .upg_done_o (upg_done_o),
    .busy_o     (busy_o),
    .frame_err_o(frame_err_o),
    .chk_err_o  (chk_err_o)
  );

  typedef struct {
    logic [14:0] adr;
    logic [31:0] dat;
  } wr_t;

  int          errors = 0;
  int          checks = 0;
  wr_t         exp_q[$];
  wr_t         e_w;
  logic [7:0]  tx_q[$];
  bit          tx_ok[$];
  bit          exp_ferr = 0;
  bit          exp_chk = 0;
  bit          done_after_wen = 0;
  int          gap_max = 3;
  logic        prev_wen = 1'b0;
  logic        prev_done = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor: every strobe must be expected, single-cycle, and match the scoreboard head
  always @(negedge clk) begin
    if (upg_wen_o) begin
      check("wen_width", {31'd0, prev_wen}, 32'd0);
      check("wen_expected", {31'd0, exp_q.size() != 0}, 32'd1);
      if (exp_q.size() != 0) begin
        e_w = exp_q.pop_front();
        check("adr", {17'd0, upg_adr_o}, {17'd0, e_w.adr});
        check("dat", upg_dat_o, e_w.dat);
      end
    end
    if (upg_done_o && !prev_done && done_after_wen)
      check("done_after_wen", {31'd0, prev_wen}, 32'd1);
    prev_wen  = upg_wen_o;
    prev_done = upg_done_o;
  end

  task automatic send_byte(input logic [7:0] b, input bit ok);
    rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      tick(CPB);
    end
    rx = ok;
    tick(CPB);
    rx = 1'b1;
    tick($urandom_range(2, gap_max));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    exp_q.delete();
    exp_ferr = 0;
    exp_chk = 0;
    done_after_wen = 0;
    tick(1);
  endtask

  task automatic check_reset_outputs();
    check("rst_wen", {31'd0, upg_wen_o}, 32'd0);
    check("rst_adr", {17'd0, upg_adr_o}, 32'd0);
    check("rst_dat", upg_dat_o, 32'd0);
    check("rst_done", {31'd0, upg_done_o}, 32'd0);
    check("rst_busy", {31'd0, busy_o}, 32'd0);
    check("rst_frame_err", {31'd0, frame_err_o}, 32'd0);
    check("rst_chk_err", {31'd0, chk_err_o}, 32'd0);
  endtask

  task automatic push(input logic [7:0] b);
    tx_q.push_back(b);
    tx_ok.push_back(1'b1);
  endtask

  task automatic push_bad(input logic [7:0] b);
    tx_q.push_back(b);
    tx_ok.push_back(1'b0);
  endtask

  // Appends the two's-complement checksum of the good data bytes when the feature is built in
  task automatic add_chk();
`ifdef UART_PROG_LOADER_CHKSUM_EN
    logic [7:0] s;
    s = 8'd0;
    for (int i = 2; i < tx_q.size(); i++)
      if (tx_ok[i]) s = s + tx_q[i];
    push(8'h00 - s);
`endif
  endtask

  // Reference model: decode the surviving bytes by protocol rules, then transmit the stream
  task automatic run_stream();
    logic [7:0]  g[$];
    logic [7:0]  h1;
    int          n;
    int          p;
    wr_t         w;
    n = 0;
    for (int i = 0; i < tx_q.size(); i++) begin
      if (tx_ok[i]) g.push_back(tx_q[i]);
      else exp_ferr = 1;
    end
    if (g.size() >= 2) begin
      h1 = g[1];
      n = int'(g[0]) + 256 * int'(h1[6:0]);
      for (int k = 0; k < n; k++) begin
        p = 2 + 4 * k;
        if (p + 3 < g.size()) begin
          w.adr = 15'(k);
          w.dat = {g[p+3], g[p+2], g[p+1], g[p]};
          exp_q.push_back(w);
        end
      end
`ifdef UART_PROG_LOADER_CHKSUM_EN
      if (n > 0 && g.size() > 2 + 4 * n) begin
        int s;
        s = 0;
        for (int i = 2; i <= 2 + 4 * n; i++) s += int'(g[i]);
        exp_chk = (s % 256) != 0;
      end
      done_after_wen = 0;
`else
      done_after_wen = (n > 0);
`endif
    end
    for (int i = 0; i < tx_q.size(); i++) begin
      send_byte(tx_q[i], tx_ok[i]);
      if (i == 0 && tx_ok[0]) check("busy_after_hdr0", {31'd0, busy_o}, 32'd1);
    end
    tx_q.delete();
    tx_ok.delete();
  endtask

  task automatic finish_load();
    int t;
    t = 0;
    while (!upg_done_o && t < 300) begin
      tick(1);
      t++;
    end
    check("done", {31'd0, upg_done_o}, 32'd1);
    tick(2);
    check("pending_writes", exp_q.size(), 32'd0);
    check("busy_done", {31'd0, busy_o}, 32'd0);
    check("frame_err", {31'd0, frame_err_o}, {31'd0, exp_ferr});
    check("chk_err", {31'd0, chk_err_o}, {31'd0, exp_chk});
  endtask

  initial begin
    rx = 1'b1;
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(1);
    check_reset_outputs();

    // two-word program
    push(8'h02); push(8'h00);
    push(8'h13); push(8'h05); push(8'h10); push(8'h00);
    push(8'h93); push(8'h05); push(8'h20); push(8'h00);
    add_chk();
    run_stream();
    finish_load();
    do_reset();

    // empty load
    push(8'h00); push(8'h00);
    run_stream();
    finish_load();
    do_reset();

    // start-bit glitch, then a one-word load
    rx = 1'b0;
    tick(3);
    rx = 1'b1;
    tick(20);
    check("glitch_busy", {31'd0, busy_o}, 32'd0);
    check("glitch_frame_err", {31'd0, frame_err_o}, 32'd0);
    check("glitch_done", {31'd0, upg_done_o}, 32'd0);
    push(8'h01); push(8'h00);
    push(8'hEF); push(8'hBE); push(8'hAD); push(8'hDE);
    add_chk();
    run_stream();
    finish_load();
    do_reset();

    // framing error byte dropped mid-load
    push(8'h01); push(8'h00);
    push_bad(8'h55);
    push(8'hAA); push(8'hBB); push(8'hCC); push(8'hDD);
    add_chk();
    run_stream();
    finish_load();
    do_reset();

    // reset part-way through a word
    push(8'h01); push(8'h00); push(8'h11); push(8'h22);
    run_stream();
    tick(5);
    do_reset();
    check_reset_outputs();
    push(8'h01); push(8'h00);
    push(8'h11); push(8'h22); push(8'h33); push(8'h44);
    add_chk();
    run_stream();
    finish_load();
    do_reset();

`ifdef UART_PROG_LOADER_CHKSUM_EN
    push(8'h01); push(8'h00);
    push(8'h01); push(8'h02); push(8'h03); push(8'h04); push(8'hF6);
    run_stream();
    finish_load();
    do_reset();
    push(8'h01); push(8'h00);
    push(8'h01); push(8'h02); push(8'h03); push(8'h04); push(8'h00);
    run_stream();
    finish_load();
    do_reset();
`endif

    // randomized loads, header bit 15 randomly set
    gap_max = 6;
    for (int k = 0; k < 4; k++) begin
      int n;
      n = $urandom_range(1, 3);
      push(8'(n));
      push(8'($urandom_range(0, 1) << 7));
      for (int i = 0; i < 4 * n; i++) push(8'($urandom_range(0, 255)));
      add_chk();
      run_stream();
      finish_load();
      do_reset();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
